// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, key-schedule FSM encoding and GF(2^8) helpers.
// Also used by the Encrypt round datapath.
package aes_pkg;

  localparam int NUM_ROUNDS_DEF = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } ks_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  // Word i of a 128-bit block; w0 is the most significant word (FIPS-197 byte order).
  function automatic logic [31:0] get_word(input logic [127:0] blk, input logic [1:0] i);
    return blk[{2'd3 - i, 5'd0} +: 32];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  // Entry 0x00 occupies the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s_o = SBOX_TABLE[{~a_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one expansion step per accepted round key.
// Optional macro AES_KEY_REPLAY_EN adds a round-key cache and a replay input.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] Key,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         done
`ifdef AES_KEY_REPLAY_EN
  ,
  input  logic         replay
`endif
);

  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("aes_key_expand supports only NUM_ROUNDS = 10");
  end

  ks_state_e    state_q, state_d;
  logic [127:0] w_q, w_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         done_q, done_d;

  logic         key_acc;
  logic         rk_acc;
  logic         last_rk;
  logic         start_replay;
  logic         replay_mode;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w, sub_w, t_w;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;

  assign key_ready = (state_q == ST_IDLE) && !reset;
  assign rk_valid  = (state_q == ST_EMIT);
  assign rk_idx    = idx_q;
  assign done      = done_q;

  assign key_acc = key_ready && key_valid;
  assign rk_acc  = rk_valid && rk_ready;
  assign last_rk = (idx_q == 4'(NUM_ROUNDS));

  assign w0    = get_word(w_q, 2'd0);
  assign w1    = get_word(w_q, 2'd1);
  assign w2    = get_word(w_q, 2'd2);
  assign w3    = get_word(w_q, 2'd3);
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_subword
    aes_sbox u_sbox (
      .a_i (rot_w[8*gi +: 8]),
      .s_o (sub_w[8*gi +: 8])
    );
  end

  assign t_w  = sub_w ^ {rcon_q, 24'h0};
  assign w0_n = w0 ^ t_w;
  assign w1_n = w1 ^ w0_n;
  assign w2_n = w2 ^ w1_n;
  assign w3_n = w3 ^ w2_n;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_acc) begin
          w_d     = Key;
          idx_d   = 4'd0;
          rcon_d  = 8'h01;
          state_d = ST_EMIT;
        end else if (start_replay) begin
          idx_d   = 4'd0;
          rcon_d  = 8'h01;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (rk_ready) begin
          if (last_rk) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            // Replayed keys come from the cache, so the live schedule stays frozen.
            if (!replay_mode) begin
              w_d    = {w0_n, w1_n, w2_n, w3_n};
              rcon_d = xtime(rcon_q);
            end
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      idx_q   <= 4'd0;
      rcon_q  <= 8'h01;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

`ifdef AES_KEY_REPLAY_EN
  logic [127:0] cache_q [0:NUM_ROUNDS];
  logic         cache_ok_q;
  logic         replay_q;

  assign start_replay = (state_q == ST_IDLE) && !reset && cache_ok_q && replay && !key_valid;
  assign replay_mode  = replay_q;
  assign rk_data      = replay_q ? cache_q[idx_q] : w_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_ok_q <= 1'b0;
      replay_q   <= 1'b0;
    end else begin
      if (key_acc) begin
        cache_ok_q <= 1'b0;
        replay_q   <= 1'b0;
      end else if (start_replay) begin
        replay_q <= 1'b1;
      end
      if (rk_acc && !replay_q && last_rk) begin
        cache_ok_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rk_acc && !replay_q) begin
      cache_q[idx_q] <= w_q;
    end
  end
`else
  assign start_replay = 1'b0;
  assign replay_mode  = 1'b0;
  assign rk_data      = w_q;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand against a FIPS-197 reference model
// (S-box derived from GF(2^8) inversion plus the affine map).
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] Key;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready;
  logic         done;
  logic         replay;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]   sbox_m   [0:255];
  logic [127:0] exp_rk   [0:10];
  logic [127:0] last_cap [0:10];

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ZERO = 128'h0;

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk       (clk),
    .reset     (reset),
    .Key       (Key),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .rk_data   (rk_data),
    .rk_idx    (rk_idx),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .done      (done)
`ifdef AES_KEY_REPLAY_EN
    ,
    .replay    (replay)
`endif
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++) begin
        if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      end
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic compute_keys(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- stimulus helpers ----------------
  // Starts one sequence (from Key or from replay) in the current cycle and follows it to done.
  task automatic run_seq(input logic [127:0] k, input int low_pct, input bit interfere,
                         input bit use_replay, input string tag);
    int e;
    int iter;
    if (!use_replay) compute_keys(k);
    n_vec++;
    if (key_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s start_key_ready got %b want 1", tag, key_ready);
    end
    if (use_replay) begin
      replay = 1'b1;
      key_valid = 1'b0;
    end else begin
      Key = k;
      key_valid = 1'b1;
    end
    @(posedge clk); #1;
    key_valid = 1'b0;
    replay = 1'b0;
    e = 0;
    iter = 0;
    while (e < 11 && iter < 3000) begin
      rk_ready = ($urandom_range(0, 99) >= low_pct);
      if (interfere) begin
        key_valid = 1'($urandom_range(0, 1));
        Key = {$urandom, $urandom, $urandom, $urandom};
      end
      n_vec++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'(e) || rk_data !== exp_rk[e] ||
          key_ready !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL %s emit cyc=%0d got valid=%b idx=%0d data=%h kr=%b done=%b want valid=1 idx=%0d data=%h kr=0 done=0",
                 tag, iter, rk_valid, rk_idx, rk_data, key_ready, done, e, exp_rk[e]);
      end
      if (rk_ready) last_cap[e] = rk_data;
      @(posedge clk); #1;
      iter++;
      if (rk_ready) e++;
    end
    key_valid = 1'b0;
    rk_ready = 1'b0;
    n_vec++;
    if (e != 11) begin
      n_err++;
      $display("FAIL %s timeout handshakes got %0d want 11", tag, e);
    end
    n_vec++;
    if (done !== 1'b1 || key_ready !== 1'b1 || rk_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s end got done=%b kr=%b valid=%b want done=1 kr=1 valid=0", tag, done, key_ready, rk_valid);
    end
    if (low_pct == 0) begin
      n_vec++;
      if (iter != 11) begin
        n_err++;
        $display("FAIL %s latency got done at N+%0d want N+12", tag, iter + 1);
      end
    end
    $display("%s: key %h, %0d cycles, rk10=%h", tag, k, iter, last_cap[10]);
  endtask

  task automatic check_done_low(input string tag);
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL %s done_pulse_width got done=%b want 0", tag, done);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (key_ready !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0 ||
        rk_data !== 128'h0 || rk_idx !== 4'd0) begin
      n_err++;
      $display("FAIL reset_values got kr=%b valid=%b done=%b idx=%0d data=%h want all 0",
               key_ready, rk_valid, done, rk_idx, rk_data);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (key_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release key_ready got %b want 1", key_ready);
    end
    $display("reset: kr=%b valid=%b done=%b", key_ready, rk_valid, done);
  endtask

  task automatic test_fips();
    run_seq(KEY_A1, 0, 1'b0, 1'b0, "fips_a1");
    n_vec++;
    if (last_cap[0] !== KEY_A1 || last_cap[1] !== 128'ha0fafe1788542cb123a339392a6c7605 ||
        last_cap[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      n_err++;
      $display("FAIL fips_a1_vectors got rk0=%h rk1=%h rk10=%h want FIPS-197 A.1 values",
               last_cap[0], last_cap[1], last_cap[10]);
    end
    check_done_low("fips_a1");
  endtask

  task automatic test_zero_key();
    run_seq(KEY_ZERO, 0, 1'b0, 1'b0, "zero_key");
    n_vec++;
    if (last_cap[1] !== 128'h62636363626363636263636362636363 ||
        last_cap[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
      n_err++;
      $display("FAIL zero_key_vectors got rk1=%h rk10=%h want known zero-key values",
               last_cap[1], last_cap[10]);
    end
    check_done_low("zero_key");
  endtask

  task automatic test_stall();
    run_seq(KEY_A1, 30, 1'b0, 1'b0, "stall_a1");
    check_done_low("stall_a1");
  endtask

  task automatic test_busy_key();
    run_seq(KEY_A1, 20, 1'b1, 1'b0, "busy_key");
    check_done_low("busy_key");
  endtask

  task automatic test_reset_mid();
    int guard;
    Key = KEY_A1;
    key_valid = 1'b1;
    rk_ready = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    guard = 0;
    while (!(rk_valid === 1'b1 && rk_idx === 4'd5) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    n_vec++;
    if (guard >= 50) begin
      n_err++;
      $display("FAIL reset_mid reach_idx5 got idx=%0d want 5", rk_idx);
    end
    rk_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_vec++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1 || rk_idx !== 4'd0 ||
        rk_data !== 128'h0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid after got valid=%b kr=%b idx=%0d data=%h done=%b want 0 1 0 0 0",
               rk_valid, key_ready, rk_idx, rk_data, done);
    end
    $display("reset_mid: abandoned at idx 5, valid=%b kr=%b", rk_valid, key_ready);
    run_seq(KEY_A1, 0, 1'b0, 1'b0, "after_reset");
    check_done_low("after_reset");
  endtask

  task automatic test_back_to_back();
    // Each new key is presented in the cycle where the previous done is high.
    for (int i = 0; i < 3; i++) begin
      run_seq({$urandom, $urandom, $urandom, $urandom}, 25, 1'b0, 1'b0, "back_to_back");
    end
    check_done_low("back_to_back");
  endtask

`ifdef AES_KEY_REPLAY_EN
  task automatic test_replay();
    run_seq(KEY_A1, 0, 1'b0, 1'b0, "replay_src");
    check_done_low("replay_src");
    run_seq(128'h0, 30, 1'b0, 1'b1, "replay");
    check_done_low("replay");
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    replay = 1'b1;
    @(posedge clk); #1;
    replay = 1'b0;
    n_vec++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
      n_err++;
      $display("FAIL replay_after_reset got valid=%b kr=%b want valid=0 kr=1", rk_valid, key_ready);
    end
    $display("replay_after_reset: valid=%b kr=%b", rk_valid, key_ready);
  endtask
`endif

  initial begin
    reset = 1'b1;
    Key = '0;
    key_valid = 1'b0;
    rk_ready = 1'b0;
    replay = 1'b0;
    build_sbox();
    test_reset();
    test_fips();
    test_zero_key();
    test_stall();
    test_busy_key();
    test_reset_mid();
    test_back_to_back();
`ifdef AES_KEY_REPLAY_EN
    test_replay();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
